// File: rtl/bp_pkg.sv
// Shared types for the branch-resolution controller: FSM states, queue entry
// layout and the sequential fall-through address helper.
package bp_pkg;

   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRACK   = 2'd1,
      RECOVER = 2'd2
   } bp_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic              taken;
      logic [ADDR_W-1:0] target;
   } bp_entry_t;

   function automatic logic [ADDR_W-1:0] fallthrough_pc(input logic [ADDR_W-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/bp_pending_fifo.sv
// Circular queue of in-flight predicted branches; clear wins over push and pop.
// Callers guarantee no push when full and no pop when empty.
module bp_pending_fifo
   import bp_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  bp_entry_t        push_entry_i,
   input  logic             pop_i,
   input  logic             clear_i,
   output bp_entry_t        head_o,
   output logic [CNT_W-1:0] count_o
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   bp_entry_t        mem_q [DEPTH];
   bp_entry_t        mem_d [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/bp_resolve_ctrl.sv
// Branch resolution controller: tracks predicted branches until EX resolves them,
// issues predictor updates and a flush/redirect on mispredict, then stalls intake.
module bp_resolve_ctrl
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH          = 2,
   parameter int unsigned RECOVER_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pred_valid_i,
   input  logic        pred_taken_i,
   input  logic [31:0] pred_pc_i,
   input  logic [31:0] pred_target_i,
   output logic        pred_ready_o,
   input  logic        res_valid_i,
   input  logic        res_taken_i,
   input  logic [31:0] res_target_i,
   output logic        flush_o,
   output logic [31:0] redirect_addr_o,
   output logic        upd_valid_o,
   output logic        upd_taken_o,
   output logic        err_o
);

   localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [3:0]       REC_LAST = 4'(RECOVER_CYCLES - 1);

   bp_state_e        state_q, state_d;
   logic [3:0]       rec_cnt_q, rec_cnt_d;
   logic             flush_q, flush_d;
   logic [31:0]      redirect_q, redirect_d;
   logic             upd_valid_q, upd_valid_d;
   logic             upd_taken_q, upd_taken_d;
   logic             err_q, err_d;

   bp_entry_t        head;
   bp_entry_t        push_entry;
   logic [CNT_W-1:0] count;
   logic             push, pop, mispredict;

   assign push_entry = '{pc: pred_pc_i, taken: pred_taken_i, target: pred_target_i};

   bp_pending_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .clear_i      (mispredict),
      .head_o       (head),
      .count_o      (count)
   );

   // Ready looks only at occupancy, so a full queue rejects a push even when
   // the head retires in the same cycle.
   always_comb begin
      pred_ready_o = (state_q != RECOVER) && (count < DEPTH_C);
      pop          = res_valid_i && (count != '0) && (state_q != RECOVER);
      mispredict   = pop && ((head.taken != res_taken_i) ||
                             (head.taken && res_taken_i && (head.target != res_target_i)));
      push         = pred_valid_i && pred_ready_o && !mispredict;
   end

   always_comb begin
      state_d     = state_q;
      rec_cnt_d   = rec_cnt_q;
      flush_d     = mispredict;
      redirect_d  = redirect_q;
      upd_valid_d = pop;
      upd_taken_d = pop && res_taken_i;
      err_d       = res_valid_i && (count == '0) && (state_q != RECOVER);

      if (mispredict) begin
         redirect_d = res_taken_i ? res_target_i : fallthrough_pc(head.pc);
         state_d    = RECOVER;
         rec_cnt_d  = REC_LAST;
      end else begin
         case (state_q)
            IDLE: begin
               if (push) state_d = TRACK;
            end
            TRACK: begin
               if (pop && !push && (count == CNT_W'(1))) state_d = IDLE;
            end
            RECOVER: begin
               if (rec_cnt_q == 4'd0) state_d   = IDLE;
               else                   rec_cnt_d = rec_cnt_q - 4'd1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rec_cnt_q   <= 4'd0;
         flush_q     <= 1'b0;
         redirect_q  <= 32'd0;
         upd_valid_q <= 1'b0;
         upd_taken_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rec_cnt_q   <= rec_cnt_d;
         flush_q     <= flush_d;
         redirect_q  <= redirect_d;
         upd_valid_q <= upd_valid_d;
         upd_taken_q <= upd_taken_d;
         err_q       <= err_d;
      end
   end

   assign flush_o         = flush_q;
   assign redirect_addr_o = redirect_q;
   assign upd_valid_o     = upd_valid_q;
   assign upd_taken_o     = upd_taken_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// Directed bench for bp_resolve_ctrl: each step queues the registered outputs
// expected one cycle later and checks them when they appear.
module tb_bp_resolve_ctrl;
   import bp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pred_valid_i, pred_taken_i;
   logic [31:0] pred_pc_i, pred_target_i;
   logic        pred_ready_o;
   logic        res_valid_i, res_taken_i;
   logic [31:0] res_target_i;
   logic        flush_o;
   logic [31:0] redirect_addr_o;
   logic        upd_valid_o, upd_taken_o, err_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        upd;
      logic        updt;
      logic        flush;
      logic        err;
      logic [31:0] addr;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_redirect = 32'd0;

   bp_resolve_ctrl #(.DEPTH(2), .RECOVER_CYCLES(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pred_valid_i    (pred_valid_i),
      .pred_taken_i    (pred_taken_i),
      .pred_pc_i       (pred_pc_i),
      .pred_target_i   (pred_target_i),
      .pred_ready_o    (pred_ready_o),
      .res_valid_i     (res_valid_i),
      .res_taken_i     (res_taken_i),
      .res_target_i    (res_target_i),
      .flush_o         (flush_o),
      .redirect_addr_o (redirect_addr_o),
      .upd_valid_o     (upd_valid_o),
      .upd_taken_o     (upd_taken_o),
      .err_o           (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag,
                       input logic pv, input logic ptk, input logic [31:0] ppc, input logic [31:0] ptgt,
                       input logic rv, input logic rtk, input logic [31:0] rtgt,
                       input logic e_ready, input logic e_upd, input logic e_updt,
                       input logic e_flush, input logic [31:0] e_addr, input logic e_err);
      exp_t e;
      pred_valid_i  = pv;
      pred_taken_i  = ptk;
      pred_pc_i     = ppc;
      pred_target_i = ptgt;
      res_valid_i   = rv;
      res_taken_i   = rtk;
      res_target_i  = rtgt;
      chk({tag, ".ready"}, 32'(pred_ready_o), 32'(e_ready));
      if (e_flush) model_redirect = e_addr;
      e.upd   = e_upd;
      e.updt  = e_updt;
      e.flush = e_flush;
      e.err   = e_err;
      e.addr  = model_redirect;
      sb.push_back(e);
      @(posedge clk);
      #1;
      pred_valid_i = 1'b0;
      res_valid_i  = 1'b0;
      e = sb.pop_front();
      chk({tag, ".upd_valid"}, 32'(upd_valid_o), 32'(e.upd));
      if (e.upd) chk({tag, ".upd_taken"}, 32'(upd_taken_o), 32'(e.updt));
      chk({tag, ".flush"}, 32'(flush_o), 32'(e.flush));
      chk({tag, ".redirect"}, redirect_addr_o, e.addr);
      chk({tag, ".err"}, 32'(err_o), 32'(e.err));
   endtask

   task automatic idle(input string tag, input logic e_ready);
      step(tag, 0, 0, 0, 0, 0, 0, 0, e_ready, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      pred_valid_i = 0; pred_taken_i = 0; pred_pc_i = 0; pred_target_i = 0;
      res_valid_i = 0; res_taken_i = 0; res_target_i = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.flush", 32'(flush_o), 0);
      chk("rst.upd_valid", 32'(upd_valid_o), 0);
      chk("rst.upd_taken", 32'(upd_taken_o), 0);
      chk("rst.err", 32'(err_o), 0);
      chk("rst.redirect", redirect_addr_o, 0);
      chk("rst.state", 32'(dut.state_q), 32'(IDLE));
      rst_n = 1'b1;

      // Correct taken prediction retires cleanly.
      step("t1.push", 1, 1, 32'h100, 32'h80, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      chk("t1.state_track", 32'(dut.state_q), 32'(TRACK));
      step("t1.res", 0, 0, 0, 0, 1, 1, 32'h80, 1, 1, 1, 0, 0, 0);
      chk("t1.state_idle", 32'(dut.state_q), 32'(IDLE));

      // Taken predicted, not taken actual: fall-through redirect, 2-cycle stall.
      step("t2.push", 1, 1, 32'h200, 32'h280, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step("t2.res", 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 32'h204, 0);
      chk("t2.state_rec", 32'(dut.state_q), 32'(RECOVER));
      idle("t2.rec1", 0);
      step("t2.rec2", 1, 1, 32'h999, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("t2.count_after", 32'(dut.u_fifo.count_q), 0);
      idle("t2.after", 1);

      // Not-taken predicted, taken actual, with a wrong-path push in the same cycle.
      step("t3.push", 1, 0, 32'h300, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step("t3.res", 1, 1, 32'h400, 32'h500, 1, 1, 32'h3C0, 1, 1, 1, 1, 32'h3C0, 0);
      chk("t3.count", 32'(dut.u_fifo.count_q), 0);
      idle("t3.rec1", 0);
      idle("t3.rec2", 0);
      chk("t3.state_idle", 32'(dut.state_q), 32'(IDLE));

      // Full queue drops pushes, including one paired with a pop.
      step("t4.pushA", 1, 1, 32'h500, 32'h600, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step("t4.pushB", 1, 0, 32'h700, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step("t4.pushC", 1, 1, 32'h900, 32'h940, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t4.count_full", 32'(dut.u_fifo.count_q), 2);
      step("t4.pushpop", 1, 1, 32'hA00, 32'hA40, 1, 1, 32'h600, 0, 1, 1, 0, 0, 0);
      chk("t4.count_one", 32'(dut.u_fifo.count_q), 1);
      step("t4.resB", 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      chk("t4.count_zero", 32'(dut.u_fifo.count_q), 0);
      chk("t4.state_idle", 32'(dut.state_q), 32'(IDLE));

      // Resolution against an empty queue.
      step("t5.err", 0, 0, 0, 0, 1, 1, 32'h123, 1, 0, 0, 0, 0, 1);
      idle("t5.after", 1);

      // Taken/taken with differing target is a mispredict.
      step("t6.push", 1, 1, 32'h640, 32'h700, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step("t6.res", 0, 0, 0, 0, 1, 1, 32'h780, 1, 1, 1, 1, 32'h780, 0);
      idle("t6.rec1", 0);
      idle("t6.rec2", 0);

      // Reset during the first RECOVER cycle.
      step("t7.push", 1, 1, 32'hFFFF_FFFC, 32'h10, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step("t7.res", 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 32'h0000_0000, 0);
      chk("t7.state_rec", 32'(dut.state_q), 32'(RECOVER));
      rst_n = 1'b0;
      #1;
      chk("t7.flush", 32'(flush_o), 0);
      chk("t7.upd_valid", 32'(upd_valid_o), 0);
      chk("t7.err", 32'(err_o), 0);
      chk("t7.redirect", redirect_addr_o, 0);
      chk("t7.state", 32'(dut.state_q), 32'(IDLE));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_redirect = 32'd0;
      step("t7.post", 1, 0, 32'h800, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      step("t7.postres", 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
